mc_la32_core: RTL and testbench
===============================

// Module: mc_la32_core
// PURPOSE
//  Parametrised multi-cycle LA32R core: one instruction at a time via FETCH/DECODE/EXEC/MEM/WB FSM.
//  Talks to variable-latency inst/data memories through req/rdy handshakes (no fixed-SRAM timing).
//  Integer subset: add.w sub.w slt sltu nor and or xor slli.w srli.w srai.w addi.w ld.w st.w jirl b bl beq bne lu12i.w.
//  Adds fault halting and a wait watchdog; sits under the SoC top in place of the single-cycle core.
// PARAMETERS
//  RESET_PC   32'h1c00_0000  PC of first fetch after reset release
//  MAX_WAIT   16             max cycles req may wait for rdy before timeout halt; 0 = watchdog off
// PORTS
//  clk               in   1   clock, all state on rising edge
//  resetn            in   1   asynchronous, active-low reset
//  inst_req          out  1   fetch request, held until inst_rdy
//  inst_addr         out  32  fetch address (= pc), stable while inst_req
//  inst_rdy          in   1   inst_rdata valid; accepted only when inst_req=1
//  inst_rdata        in   32  fetched instruction
//  data_req          out  1   data access request, held until data_rdy
//  data_we           out  4   byte write strobes; 4'hf for st.w, 0 for ld.w
//  data_addr         out  32  word-aligned data address
//  data_wdata        out  32  store data
//  data_rdy          in   1   access complete; data_rdata valid for loads
//  data_rdata        in   32  load data
//  halted            out  1   core stopped on fault
//  halt_cause        out  2   0 none, 1 illegal inst, 2 misaligned ld/st, 3 watchdog timeout
//  perf_cycles       out  32  cycle counter (see CONFIGURATION)
//  perf_retired      out  32  retired-instruction counter (see CONFIGURATION)
//  debug_wb_pc       out  32  pc of instruction in WB/retire
//  debug_wb_rf_we    out  4   4'hf in the one retire cycle that writes a GPR, else 0
//  debug_wb_rf_wnum  out  5   destination register
//  debug_wb_rf_wdata out  32  write data
// BEHAVIOUR
//  - Reset (resetn=0, async): state=FETCH, pc=RESET_PC, all req/we/debug outs 0, halted=0, halt_cause=0, counters 0.
//    Reset mid-access drops inst_req/data_req immediately; in-flight rdy after release ignored unless req=1.
//  - States: FETCH -> DECODE -> EXEC -> {MEM ->} {WB ->} FETCH; HALT absorbing until reset.
//  - FETCH: inst_req=1; on inst_rdy capture inst, -> DECODE. Zero-wait memory (rdy same cycle) = 1 cycle.
//  - DECODE: read rj, rk/rd (rd for beq/bne/st.w); unknown encoding -> HALT, cause 1.
//  - EXEC: ALU result; b/beq/bne resolve, pc <= taken ? target : pc+4, -> FETCH (3 cycles).
//    ld.w/st.w -> MEM; addr[1:0]!=0 -> HALT, cause 2, no data_req issued. Others -> WB.
//  - MEM: data_req=1 until data_rdy; st.w -> FETCH (pc+4, 4 cycles); ld.w -> WB with data_rdata.
//  - WB: GPR write if dest!=0 else suppressed (debug_wb_rf_we=0); pc <= pc+4, or target for jirl/bl.
//    Latencies at zero wait: ALU 4, load 5, store 4, bl/jirl 4 (link = pc+4 to r1 / rd).
//  - Branch targets: b/bl pc+sext(offs26<<2); beq/bne pc+sext(offs16<<2); jirl rj+sext(offs16<<2).
//  - Retire = last cycle of instruction (WB, or EXEC for branches, MEM for stores).
//  - GPRs: 32x32 internal, r0 reads 0. Writes in WB; next DECODE sees them (no bypass needed).
//  - Shifts use rk[4:0]/ui5; slt signed, sltu unsigned; all arithmetic wraps mod 2^32.
//  - Watchdog (MAX_WAIT>0): per-request counter; reaches MAX_WAIT with no rdy -> HALT cause 3, req dropped.
//  - HALT: all req 0, pc frozen, halted=1; first fault wins; inputs ignored.
//  - pc+4 wrap 32'hffff_fffc -> 0 permitted, no fault.
// CONFIGURATION
//  MC_LA32_PERF_CNT_EN defined: perf_cycles +1 every non-reset cycle (stops in HALT);
//    perf_retired +1 per retire; both wrap at 2^32.
//  Undefined: both outputs tied 32'h0, no counter flops.
// TESTING
//  1. addi.w r1,r0,5; add.w r2,r1,r1, zero-wait mem -> r2=10, retire at cycles 4 and 8, wnum 1 then 2.
//  2. Fetch with inst_rdy delayed 3 cycles -> inst_req and inst_addr held stable 4 cycles, result unchanged.
//  3. st.w r2,0(r3=0x100) then ld.w r4,0(r3) -> data_we=4'hf addr 0x100 wdata 10; r4=10 at load WB.
//  4. beq r0,r0,-4 at pc 0x1c000010 -> next inst_addr 0x1c00000c after 3 cycles; bl writes r1=pc+4.
//  5. Fault cases: inst 32'hffffffff -> halted=1, cause 1; ld.w at addr 0x102 -> cause 2, no data_req;
//     MAX_WAIT=16 with inst_rdy stuck 0 -> cause 3 after 16 req cycles.
//  6. Assert resetn low mid data_req -> req falls without clock edge; after release inst_addr=RESET_PC,
//     perf counters 0 (with MC_LA32_PERF_CNT_EN).

Source files
------------

// File: rtl/mc_la32_core_if.sv
// rtl/mc_la32_core_if.sv - instruction/data memory req/rdy bus between mc_la32_core and its memories
interface mc_la32_core_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_rdy;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_rdy;
  logic [31:0] data_rdata;

  modport master (
    output inst_req, inst_addr, data_req, data_we, data_addr, data_wdata,
    input  inst_rdy, inst_rdata, data_rdy, data_rdata
  );

  modport slave (
    input  inst_req, inst_addr, data_req, data_we, data_addr, data_wdata,
    output inst_rdy, inst_rdata, data_rdy, data_rdata
  );
endinterface

// File: rtl/mc_la32_core.sv
// rtl/mc_la32_core.sv - multi-cycle LA32R integer core with req/rdy memories, fault halt and wait watchdog
// Optional cycle/retire counters are built when MC_LA32_PERF_CNT_EN is defined.
module mc_la32_core #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  mc_la32_core_if.master        bus,
  output logic                  halted_o,
  output logic [1:0]            halt_cause_o,
  output logic [31:0]           perf_cycles_o,
  output logic [31:0]           perf_retired_o,
  output logic [31:0]           debug_wb_pc_o,
  output logic [3:0]            debug_wb_rf_we_o,
  output logic [4:0]            debug_wb_rf_wnum_o,
  output logic [31:0]           debug_wb_rf_wdata_o
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [4:0] {
    OP_ILL, OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_NOR, OP_AND, OP_OR, OP_XOR,
    OP_SLLI, OP_SRLI, OP_SRAI, OP_ADDI, OP_LU12I, OP_LD, OP_ST,
    OP_JIRL, OP_B, OP_BL, OP_BEQ, OP_BNE
  } op_e;

  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   res_q, res_d;
  logic [31:0]   tgt_q, tgt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [1:0]    cause_q, cause_d;
  logic [31:0]   rf_q [32];

  op_e         op;
  logic [4:0]  rd, rj, rk, dest, ui5;
  logic [31:0] si12, off16, off26, pc_plus4, alu, rf_rj, rf_rk;
  logic        use_rd, fetch_req, mem_req, rf_we, retire, wdog_hit;

  assign rd       = inst_q[4:0];
  assign rj       = inst_q[9:5];
  assign rk       = inst_q[14:10];
  assign ui5      = inst_q[14:10];
  assign si12     = {{20{inst_q[21]}}, inst_q[21:10]};
  assign off16    = {{14{inst_q[25]}}, inst_q[25:10], 2'b00};
  assign off26    = {{4{inst_q[9]}}, inst_q[9:0], inst_q[25:10], 2'b00};
  assign pc_plus4 = pc_q + 32'd4;
  assign dest     = (op == OP_BL) ? 5'd1 : rd;
  assign use_rd   = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_ST);
  assign wdog_hit = (MAX_WAIT != 0) && (wait_q == WAIT_LAST);

  // r0 is never written, but its storage is not reset, so force the read to zero.
  assign rf_rj = (rj == 5'd0) ? 32'h0 : rf_q[rj];
  assign rf_rk = (use_rd ? rd : rk) == 5'd0 ? 32'h0 : rf_q[use_rd ? rd : rk];

  always_comb begin
    op = OP_ILL;
    case (inst_q[31:15])
      17'h00020: op = OP_ADD;
      17'h00022: op = OP_SUB;
      17'h00024: op = OP_SLT;
      17'h00025: op = OP_SLTU;
      17'h00028: op = OP_NOR;
      17'h00029: op = OP_AND;
      17'h0002a: op = OP_OR;
      17'h0002b: op = OP_XOR;
      17'h00081: op = OP_SLLI;
      17'h00089: op = OP_SRLI;
      17'h00091: op = OP_SRAI;
      default:   ;
    endcase
    case (inst_q[31:22])
      10'h00a: op = OP_ADDI;
      10'h0a2: op = OP_LD;
      10'h0a6: op = OP_ST;
      default: ;
    endcase
    if (inst_q[31:25] == 7'h0a) op = OP_LU12I;
    case (inst_q[31:26])
      6'h13:   op = OP_JIRL;
      6'h14:   op = OP_B;
      6'h15:   op = OP_BL;
      6'h16:   op = OP_BEQ;
      6'h17:   op = OP_BNE;
      default: ;
    endcase
  end

  always_comb begin
    alu = 32'h0;
    case (op)
      OP_ADD:               alu = a_q + b_q;
      OP_SUB:               alu = a_q - b_q;
      OP_SLT:               alu = {31'h0, $signed(a_q) < $signed(b_q)};
      OP_SLTU:              alu = {31'h0, a_q < b_q};
      OP_NOR:               alu = ~(a_q | b_q);
      OP_AND:               alu = a_q & b_q;
      OP_OR:                alu = a_q | b_q;
      OP_XOR:               alu = a_q ^ b_q;
      OP_SLLI:              alu = a_q << ui5;
      OP_SRLI:              alu = a_q >> ui5;
      OP_SRAI:              alu = $unsigned($signed(a_q) >>> ui5);
      OP_ADDI, OP_LD, OP_ST: alu = a_q + si12;
      OP_LU12I:             alu = {inst_q[24:5], 12'h0};
      OP_JIRL, OP_BL:       alu = pc_plus4;
      default:              alu = 32'h0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    tgt_d     = tgt_q;
    wait_d    = '0;
    cause_d   = cause_q;
    fetch_req = 1'b0;
    mem_req   = 1'b0;
    rf_we     = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: begin
        fetch_req = 1'b1;
        if (bus.inst_rdy) begin
          inst_d  = bus.inst_rdata;
          state_d = S_DECODE;
        end else if (wdog_hit) begin
          state_d = S_HALT;
          cause_d = 2'd3;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_DECODE: begin
        a_d = rf_rj;
        b_d = rf_rk;
        if (op == OP_ILL) begin
          state_d = S_HALT;
          cause_d = 2'd1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d = alu;
        tgt_d = (op == OP_JIRL) ? a_q + off16 : pc_q + off26;
        case (op)
          OP_B: begin
            retire  = 1'b1;
            pc_d    = pc_q + off26;
            state_d = S_FETCH;
          end
          OP_BEQ, OP_BNE: begin
            retire  = 1'b1;
            pc_d    = ((a_q == b_q) == (op == OP_BEQ)) ? pc_q + off16 : pc_plus4;
            state_d = S_FETCH;
          end
          OP_LD, OP_ST: begin
            // A misaligned access faults here so the data bus never sees it.
            if (alu[1:0] != 2'b00) begin
              state_d = S_HALT;
              cause_d = 2'd2;
            end else begin
              state_d = S_MEM;
            end
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        if (bus.data_rdy) begin
          if (op == OP_ST) begin
            retire  = 1'b1;
            pc_d    = pc_plus4;
            state_d = S_FETCH;
          end else begin
            res_d   = bus.data_rdata;
            state_d = S_WB;
          end
        end else if (wdog_hit) begin
          state_d = S_HALT;
          cause_d = 2'd3;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_WB: begin
        retire  = 1'b1;
        rf_we   = (dest != 5'd0);
        pc_d    = (op == OP_JIRL || op == OP_BL) ? tgt_q : pc_plus4;
        state_d = S_FETCH;
      end
      S_HALT:  ;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      res_q   <= 32'h0;
      tgt_q   <= 32'h0;
      wait_q  <= '0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      tgt_q   <= tgt_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rf_we) rf_q[dest] <= res_q;
  end

  // FETCH is the reset state, so the fetch request is masked while reset is held.
  assign bus.inst_req   = fetch_req && resetn_i;
  assign bus.inst_addr  = pc_q;
  assign bus.data_req   = mem_req;
  assign bus.data_we    = (mem_req && op == OP_ST) ? 4'hf : 4'h0;
  assign bus.data_addr  = res_q;
  assign bus.data_wdata = b_q;

  assign halted_o            = (state_q == S_HALT);
  assign halt_cause_o        = cause_q;
  assign debug_wb_pc_o       = retire ? pc_q : 32'h0;
  assign debug_wb_rf_we_o    = rf_we ? 4'hf : 4'h0;
  assign debug_wb_rf_wnum_o  = (state_q == S_WB) ? dest : 5'd0;
  assign debug_wb_rf_wdata_o = (state_q == S_WB) ? res_q : 32'h0;

`ifdef MC_LA32_PERF_CNT_EN
  logic [31:0] cycles_q, retired_q;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cycles_q  <= 32'h0;
      retired_q <= 32'h0;
    end else begin
      if (state_q != S_HALT) cycles_q <= cycles_q + 32'd1;
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

  assign perf_cycles_o  = cycles_q;
  assign perf_retired_o = retired_q;
`else
  assign perf_cycles_o  = 32'h0;
  assign perf_retired_o = 32'h0;
`endif

endmodule

// File: tb/tb_mc_la32_core.sv
// tb/tb_mc_la32_core.sv - directed self-checking bench for mc_la32_core
module tb_mc_la32_core;
  localparam logic [31:0] BASE = 32'h1c00_0000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mc_la32_core_if mif();

  logic        halted;
  logic [1:0]  cause;
  logic [31:0] pcyc, pret, wpc, wdata;
  logic [3:0]  wwe;
  logic [4:0]  wnum;

  mc_la32_core #(.RESET_PC(BASE), .MAX_WAIT(16)) dut (
    .clk_i               (clk),
    .resetn_i            (resetn),
    .bus                 (mif),
    .halted_o            (halted),
    .halt_cause_o        (cause),
    .perf_cycles_o       (pcyc),
    .perf_retired_o      (pret),
    .debug_wb_pc_o       (wpc),
    .debug_wb_rf_we_o    (wwe),
    .debug_wb_rf_wnum_o  (wnum),
    .debug_wb_rf_wdata_o (wdata)
  );

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  int   inst_lat   = 0;
  logic inst_stuck = 1'b0;
  logic data_stuck = 1'b0;
  int   ist_cnt    = 0;
  int   tick       = 0;
  int   dreq_cnt   = 0;
  int   t0         = 0;
  int   errors     = 0;
  int   checks     = 0;

  assign mif.inst_rdy   = mif.inst_req && !inst_stuck && (ist_cnt >= inst_lat);
  assign mif.inst_rdata = imem[mif.inst_addr[7:2]];
  assign mif.data_rdy   = mif.data_req && !data_stuck;
  assign mif.data_rdata = dmem[mif.data_addr[7:2]];

  always @(posedge clk) begin
    tick    <= tick + 1;
    ist_cnt <= (mif.inst_req && !mif.inst_rdy) ? ist_cnt + 1 : 0;
    if (mif.data_req) dreq_cnt <= dreq_cnt + 1;
    if (mif.data_req && mif.data_rdy && mif.data_we == 4'hf)
      dmem[mif.data_addr[7:2]] <= mif.data_wdata;
  end

  function automatic logic [31:0] r3(input logic [16:0] op, input logic [4:0] rd, input logic [4:0] rj, input logic [4:0] rk);
    return {op, rk, rj, rd};
  endfunction
  function automatic logic [31:0] ri12(input logic [9:0] op, input logic [4:0] rd, input logic [4:0] rj, input logic [11:0] si);
    return {op, si, rj, rd};
  endfunction
  function automatic logic [31:0] ri5(input logic [16:0] op, input logic [4:0] rd, input logic [4:0] rj, input logic [4:0] ui);
    return {op, ui, rj, rd};
  endfunction
  function automatic logic [31:0] lu12i(input logic [4:0] rd, input logic [19:0] si);
    return {7'h0a, si, rd};
  endfunction
  function automatic logic [31:0] br16(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rj, input logic [15:0] offs);
    return {op, offs, rj, rd};
  endfunction
  function automatic logic [31:0] br26(input logic [5:0] op, input logic [25:0] offs);
    return {op, offs[15:0], offs[25:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    t0 = tick;
  endtask

  task automatic wait_retire(input string tag, output int cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (wpc == 32'h0 && n < 40);
    cyc = tick - t0 + 1;
    chk({tag, "_seen"}, 32'(wpc != 32'h0), 32'd1);
  endtask

  task automatic chk_ret(input string tag, input int ecyc, input logic [31:0] epc,
                         input logic [4:0] enum_, input logic [31:0] edata);
    int cyc;
    wait_retire(tag, cyc);
    chk({tag, "_cycle"}, 32'(cyc), 32'(ecyc));
    chk({tag, "_pc"}, wpc, epc);
    chk({tag, "_we"}, 32'(wwe), 32'hf);
    chk({tag, "_wnum"}, 32'(wnum), 32'(enum_));
    chk({tag, "_wdata"}, wdata, edata);
  endtask

  task automatic chk_ret_nw(input string tag, input int ecyc, input logic [31:0] epc);
    int cyc;
    wait_retire(tag, cyc);
    chk({tag, "_cycle"}, 32'(cyc), 32'(ecyc));
    chk({tag, "_pc"}, wpc, epc);
    chk({tag, "_we"}, 32'(wwe), 32'h0);
  endtask

  task automatic wait_halt(input string tag);
    int n;
    n = 0;
    while (!halted && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_halted"}, 32'(halted), 32'd1);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'hffff_ffff;
  endtask

  task automatic load_prog_a();
    clear_imem();
    imem[0]  = ri12(10'h00a, 5'd1, 5'd0, 12'd5);
    imem[1]  = r3(17'h20, 5'd2, 5'd1, 5'd1);
    imem[2]  = ri12(10'h00a, 5'd3, 5'd0, 12'h100);
    imem[3]  = ri12(10'h0a6, 5'd2, 5'd3, 12'd0);
    imem[4]  = ri12(10'h0a2, 5'd4, 5'd3, 12'd0);
    imem[5]  = r3(17'h22, 5'd5, 5'd0, 5'd1);
    imem[6]  = r3(17'h24, 5'd6, 5'd5, 5'd1);
    imem[7]  = r3(17'h25, 5'd7, 5'd5, 5'd1);
    imem[8]  = ri5(17'h91, 5'd8, 5'd5, 5'd1);
    imem[9]  = ri5(17'h89, 5'd9, 5'd5, 5'd28);
    imem[10] = ri5(17'h81, 5'd10, 5'd1, 5'd3);
    imem[11] = lu12i(5'd11, 20'h12345);
    imem[12] = r3(17'h28, 5'd12, 5'd0, 5'd0);
    imem[13] = r3(17'h2b, 5'd13, 5'd1, 5'd2);
    imem[14] = br26(6'h15, 26'd2);
    imem[15] = ri12(10'h00a, 5'd14, 5'd0, 12'd1);
    imem[16] = ri12(10'h00a, 5'd0, 5'd0, 12'd7);
    imem[17] = ri12(10'h0a2, 5'd15, 5'd3, 12'd2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int cyc;
    int dreq_snap;
    for (int i = 0; i < 64; i++) dmem[i] = 32'h0;
    clear_imem();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_inst_req", 32'(mif.inst_req), 32'd0);
    chk("rst_data_req", 32'(mif.data_req), 32'd0);
    chk("rst_data_we", 32'(mif.data_we), 32'd0);
    chk("rst_inst_addr", mif.inst_addr, BASE);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_cause", 32'(cause), 32'd0);
    chk("rst_wb_we", 32'(wwe), 32'd0);
    chk("rst_wb_pc", wpc, 32'h0);
    chk("rst_perf_cyc", pcyc, 32'h0);
    chk("rst_perf_ret", pret, 32'h0);

    // ALU, store/load, bl, r0 suppression, misaligned load, zero-wait memories
    load_prog_a();
    do_reset();
    chk_ret("a_addi", 4, BASE + 32'h00, 5'd1, 32'd5);
`ifdef MC_LA32_PERF_CNT_EN
    chk("a_perf_cyc4", pcyc, 32'd3);
    chk("a_perf_ret4", pret, 32'd0);
`else
    chk("a_perf_cyc_tied", pcyc, 32'd0);
    chk("a_perf_ret_tied", pret, 32'd0);
`endif
    chk_ret("a_add", 8, BASE + 32'h04, 5'd2, 32'd10);
    chk_ret("a_addi_r3", 12, BASE + 32'h08, 5'd3, 32'h100);
    chk_ret_nw("a_st", 16, BASE + 32'h0c);
    chk("a_st_req", 32'(mif.data_req), 32'd1);
    chk("a_st_we", 32'(mif.data_we), 32'hf);
    chk("a_st_addr", mif.data_addr, 32'h100);
    chk("a_st_wdata", mif.data_wdata, 32'd10);
    chk_ret("a_ld", 21, BASE + 32'h10, 5'd4, 32'd10);
    chk_ret("a_sub", 25, BASE + 32'h14, 5'd5, 32'hffff_fffb);
    chk_ret("a_slt", 29, BASE + 32'h18, 5'd6, 32'd1);
    chk_ret("a_sltu", 33, BASE + 32'h1c, 5'd7, 32'd0);
    chk_ret("a_srai", 37, BASE + 32'h20, 5'd8, 32'hffff_fffd);
    chk_ret("a_srli", 41, BASE + 32'h24, 5'd9, 32'h0000_000f);
    chk_ret("a_slli", 45, BASE + 32'h28, 5'd10, 32'd40);
    chk_ret("a_lu12i", 49, BASE + 32'h2c, 5'd11, 32'h1234_5000);
    chk_ret("a_nor", 53, BASE + 32'h30, 5'd12, 32'hffff_ffff);
    chk_ret("a_xor", 57, BASE + 32'h34, 5'd13, 32'd15);
    chk_ret("a_bl", 61, BASE + 32'h38, 5'd1, BASE + 32'h3c);
    chk_ret_nw("a_r0", 65, BASE + 32'h40);
    dreq_snap = dreq_cnt;
    wait_halt("a_mis");
    chk("a_mis_cause", 32'(cause), 32'd2);
    repeat (3) @(negedge clk);
    chk("a_mis_no_dreq", 32'(dreq_cnt), 32'(dreq_snap));
    chk("a_halt_ireq", 32'(mif.inst_req), 32'd0);
    chk("a_halt_pc", mif.inst_addr, BASE + 32'h44);
`ifdef MC_LA32_PERF_CNT_EN
    chk("a_perf_cyc_halt", pcyc, 32'd68);
    chk("a_perf_ret_halt", pret, 32'd16);
`endif

    // Instruction memory answering after 3 wait cycles
    inst_lat = 3;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("lat_ireq_c%0d", i), 32'(mif.inst_req), 32'd1);
      chk($sformatf("lat_iaddr_c%0d", i), mif.inst_addr, BASE);
      @(negedge clk);
    end
    chk_ret("lat_addi", 7, BASE, 5'd1, 32'd5);
    chk_ret("lat_add", 14, BASE + 32'h04, 5'd2, 32'd10);
    inst_lat = 0;

    // Branches, jirl and illegal instruction
    clear_imem();
    imem[0]  = br26(6'h14, 26'd4);
    imem[4]  = br16(6'h16, 5'd0, 5'd0, 16'hffff);
    imem[3]  = br26(6'h14, 26'd3);
    imem[6]  = lu12i(5'd6, 20'h1c000);
    imem[7]  = br16(6'h13, 5'd7, 5'd6, 16'd9);
    imem[8]  = ri12(10'h00a, 5'd8, 5'd0, 12'd1);
    imem[9]  = br16(6'h17, 5'd0, 5'd6, 16'd2);
    imem[10] = ri12(10'h00a, 5'd8, 5'd0, 12'd1);
    do_reset();
    chk_ret_nw("br_b", 3, BASE);
    chk_ret_nw("br_beq", 6, BASE + 32'h10);
    @(negedge clk);
    chk("br_beq_target", mif.inst_addr, BASE + 32'h0c);
    chk_ret_nw("br_b2", 9, BASE + 32'h0c);
    chk_ret("br_lu12i", 13, BASE + 32'h18, 5'd6, 32'h1c00_0000);
    chk_ret("br_jirl", 17, BASE + 32'h1c, 5'd7, BASE + 32'h20);
    chk_ret_nw("br_bne", 20, BASE + 32'h24);
    wait_halt("ill");
    chk("ill_cause", 32'(cause), 32'd1);
    chk("ill_pc", mif.inst_addr, BASE + 32'h2c);

    // Fetch watchdog: no inst_rdy ever
    inst_stuck = 1'b1;
    do_reset();
    repeat (15) @(negedge clk);
    chk("wd_c16_halted", 32'(halted), 32'd0);
    chk("wd_c16_ireq", 32'(mif.inst_req), 32'd1);
    @(negedge clk);
    chk("wd_c17_halted", 32'(halted), 32'd1);
    chk("wd_cause", 32'(cause), 32'd3);
    chk("wd_ireq_drop", 32'(mif.inst_req), 32'd0);
    inst_stuck = 1'b0;
    repeat (3) @(negedge clk);
    chk("wd_absorb_halted", 32'(halted), 32'd1);
    chk("wd_absorb_ireq", 32'(mif.inst_req), 32'd0);

    // Asynchronous reset during a stalled data access
    load_prog_a();
    data_stuck = 1'b1;
    do_reset();
    n = 0;
    while (!mif.data_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ar_dreq_up", 32'(mif.data_req), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("ar_dreq_drop", 32'(mif.data_req), 32'd0);
    chk("ar_ireq_low", 32'(mif.inst_req), 32'd0);
    chk("ar_we_low", 32'(mif.data_we), 32'd0);
    @(negedge clk);
    data_stuck = 1'b0;
    resetn = 1'b1;
    t0 = tick;
    #1;
    chk("ar_iaddr", mif.inst_addr, BASE);
    chk("ar_ireq", 32'(mif.inst_req), 32'd1);
    chk("ar_halted", 32'(halted), 32'd0);
    chk("ar_perf_cyc", pcyc, 32'h0);
    chk("ar_perf_ret", pret, 32'h0);
    chk_ret("ar_addi", 4, BASE, 5'd1, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
